// File: rtl/sd_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sd_block_feeder
// Purpose  : Ping-pong sample buffer between the acquisition front end and
//            the SD-card single-block writer. Packs 16-bit samples into two
//            WORDS-deep banks. It requests a block write for each full bank
//            and answers the writer's per-word requests from that bank.
// Revision : 1.0 - initial release
// ============================================================================
module sd_block_feeder #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic        clk_ref_180deg,
    input  logic        rst_n,
    input  logic        acq_en,
    input  logic [15:0] smp_data,
    input  logic        smp_valid,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [15:0] wr_data,
    output logic        buf_overflow,
    output logic [15:0] blk_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [15:0]     mem [0:2*WORDS-1];
    logic [1:0]      full;
    logic            fill_bank;
    logic            drain_bank;
    logic [AW-1:0]   fill_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            fill_hit;
    logic            fill_last;
    logic            serve;
    logic            release_bank;
    logic [1:0]      full_set;
    logic [1:0]      full_clr;

    // A sample is stored only when its target bank is not awaiting drain.
    assign fill_hit     = smp_valid && acq_en && !full[fill_bank];
    assign fill_last    = fill_hit && (fill_ptr == LAST_IDX);
    assign serve        = (state == ST_XFER) && wr_req;
    assign release_bank = (state == ST_DONE) && !wr_busy;

    // Filling and releasing always target different banks, so both may apply.
    assign full_set = {fill_last &&  fill_bank,    fill_last && !fill_bank};
    assign full_clr = {release_bank && drain_bank, release_bank && !drain_bank};

    // Sample storage; contents need no reset because the full flags gate use.
    always_ff @(posedge clk_ref_180deg) begin
        if (fill_hit) begin
            mem[{fill_bank, fill_ptr}] <= smp_data;
        end
    end

    // Fill pointer, fill bank and sticky overflow; acq_en low discards a partial bank.
    always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
        if (!rst_n) begin
            fill_ptr     <= '0;
            fill_bank    <= 1'b0;
            buf_overflow <= 1'b0;
        end else if (!acq_en) begin
            fill_ptr     <= '0;
            buf_overflow <= 1'b0;
        end else if (smp_valid) begin
            if (full[fill_bank]) begin
                buf_overflow <= 1'b1;
            end else begin
                fill_ptr <= fill_ptr + AW'(1);
                if (fill_ptr == LAST_IDX) begin
                    fill_bank <= ~fill_bank;
                end
            end
        end
    end

    // Bank-full flags: set by the fill side, cleared when the writer finishes.
    always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

    // Drain FSM state register; the start level is registered to stay glitch-free.
    always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_start_en <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_start_en <= (state_nxt == ST_START);
        end
    end

    // Drain FSM next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (full[drain_bank] && !wr_busy)     state_nxt = ST_START;
            ST_START: if (wr_busy)                          state_nxt = ST_XFER;
            ST_XFER:  if (wr_req && (rd_ptr == LAST_IDX))   state_nxt = ST_DONE;
            ST_DONE:  if (!wr_busy)                         state_nxt = ST_IDLE;
            default:                                        state_nxt = ST_IDLE;
        endcase
    end

    // Read pointer, returned word, drain bank and handed-off block counter.
    always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_data    <= 16'h0000;
            drain_bank <= 1'b0;
            blk_cnt    <= 16'h0000;
        end else begin
            if ((state == ST_IDLE) && (state_nxt == ST_START)) begin
                rd_ptr <= '0;
            end else if (serve) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (serve) begin
                wr_data <= mem[{drain_bank, rd_ptr}];
            end
            if (release_bank) begin
                drain_bank <= ~drain_bank;
                blk_cnt    <= blk_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_block_feeder
// Purpose  : Self-checking bench for sd_block_feeder with an SD writer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_block_feeder;

    localparam int WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acq_en;
    logic [15:0] smp_data;
    logic        smp_valid;
    logic        wr_busy;
    logic        wr_req_m;
    logic        spur_req;
    logic        wr_req;
    logic        wr_start_en;
    logic [15:0] wr_data;
    logic        buf_overflow;
    logic [15:0] blk_cnt;

    // writer model state (written only by the writer process)
    logic [15:0] got [$];
    int          blocks_done = 0;
    int          req_count   = 0;
    // writer controls (written only by the main process)
    bit          stall;
    int          req_gap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int nsamp;
        int spacing;
        int gap;
        int base;
        int exp_blocks;
        int exp_ovf;
    } vec_t;

    vec_t vecs [3];

    assign wr_req = wr_req_m | spur_req;

    always #5 clk = ~clk;

    sd_block_feeder #(.WORDS(WORDS), .AW(8)) dut (
        .clk_ref_180deg (clk),
        .rst_n          (rst_n),
        .acq_en         (acq_en),
        .smp_data       (smp_data),
        .smp_valid      (smp_valid),
        .wr_busy        (wr_busy),
        .wr_req         (wr_req),
        .wr_start_en    (wr_start_en),
        .wr_data        (wr_data),
        .buf_overflow   (buf_overflow),
        .blk_cnt        (blk_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_block(input int start, input int base, input string name);
        int bad;
        int first;
        int first_act;
        logic [15:0] exp;
        bad = 0;
        first = -1;
        first_act = -1;
        for (int j = 0; j < WORDS; j++) begin
            exp = 16'(base + j);
            if (start + j >= got.size()) begin
                bad++;
                if (first < 0) first = j;
            end else if (got[start + j] !== exp) begin
                bad++;
                if (first < 0) begin
                    first = j;
                    first_act = int'(got[start + j]);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad words, first at %0d got 0x%0h, required 0x%0h",
                     name, bad, first, first_act, 16'(base + first));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_samples(input int n, input int base, input int spacing);
        for (int i = 0; i < n; i++) begin
            smp_data  = 16'(base + i);
            smp_valid = 1'b1;
            @(negedge clk);
            smp_valid = 1'b0;
            for (int g = 1; g < spacing; g++) @(negedge clk);
        end
    endtask

    task automatic wait_blocks(input int target, input string name);
        int cyc;
        cyc = 0;
        while (blocks_done < target && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " writer done"}, 32'(blocks_done >= target), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // SD writer model: answers a start level with busy, then WORDS requests.
    initial begin : writer
        bit aborted;
        wr_busy  = 1'b0;
        wr_req_m = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && wr_start_en && !wr_busy) begin
                wr_busy = 1'b1;
                aborted = 1'b0;
                @(negedge clk);
                for (int k = 0; k < WORDS && !aborted; k++) begin
                    wr_req_m = 1'b1;
                    @(negedge clk);
                    wr_req_m = 1'b0;
                    if (!rst_n) begin
                        aborted = 1'b1;
                    end else begin
                        got.push_back(wr_data);
                        req_count++;
                        for (int g = 0; g < req_gap; g++) @(negedge clk);
                    end
                end
                if (!aborted) begin
                    while (stall) @(negedge clk);
                    @(negedge clk);
                    blocks_done++;
                end
                wr_busy = 1'b0;
            end
        end
    end

    initial begin : main
        int bg;
        int bb;
        int br;
        int cyc;

        vecs[0] = '{768, 2, 0, 32'h0000, 3, 0};
        vecs[1] = '{512, 3, 1, 32'h5A00, 2, 0};
        vecs[2] = '{256, 1, 2, 32'hBEEF, 1, 0};

        rst_n     = 1'b0;
        acq_en    = 1'b1;
        smp_data  = 16'h0000;
        smp_valid = 1'b0;
        spur_req  = 1'b0;
        stall     = 1'b0;
        req_gap   = 1;

        // reset values
        do_reset();
        check("rst wr_start_en",  32'(wr_start_en),  32'd0);
        check("rst wr_data",      32'(wr_data),      32'h0);
        check("rst buf_overflow", 32'(buf_overflow), 32'd0);
        check("rst blk_cnt",      32'(blk_cnt),      32'd0);

        // single block: start level timing, data order, block count
        bg = got.size();
        bb = blocks_done;
        send_samples(WORDS, 0, 1);
        check("start 1 edge after last", 32'(wr_start_en), 32'd0);
        @(negedge clk);
        check("start 2 edges after last", 32'(wr_start_en), 32'd1);
        wait_blocks(bb + 1, "single");
        check_block(bg, 0, "single data");
        check("single blk_cnt", 32'(blk_cnt), 32'd1);

        // table-driven streaming vectors
        for (int v = 0; v < 3; v++) begin
            do_reset();
            req_gap = vecs[v].gap;
            bg = got.size();
            bb = blocks_done;
            send_samples(vecs[v].nsamp, vecs[v].base, vecs[v].spacing);
            wait_blocks(bb + vecs[v].exp_blocks, $sformatf("vec%0d", v));
            for (int b = 0; b < vecs[v].exp_blocks; b++) begin
                check_block(bg + WORDS * b, vecs[v].base + WORDS * b,
                            $sformatf("vec%0d blk%0d", v, b));
            end
            check($sformatf("vec%0d blk_cnt", v), 32'(blk_cnt), 32'(vecs[v].exp_blocks));
            check($sformatf("vec%0d overflow", v), 32'(buf_overflow), 32'(vecs[v].exp_ovf));
        end

        // writer stalled in DONE while 600 samples arrive
        do_reset();
        req_gap = 0;
        stall   = 1'b1;
        bg = got.size();
        bb = blocks_done;
        send_samples(2 * WORDS, 0, 1);
        check("stall ovf after 512", 32'(buf_overflow), 32'd0);
        send_samples(88, 2 * WORDS, 1);
        check("stall ovf after 600", 32'(buf_overflow), 32'd1);
        cyc = 0;
        while (got.size() < bg + WORDS && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("stall blk_cnt held", 32'(blk_cnt), 32'd0);
        stall = 1'b0;
        wait_blocks(bb + 2, "stall");
        check_block(bg, 0, "stall blk0");
        check_block(bg + WORDS, WORDS, "stall blk1");
        check("stall blk_cnt", 32'(blk_cnt), 32'd2);
        check("stall ovf sticky", 32'(buf_overflow), 32'd1);

        // acq_en drop discards the partial bank and clears overflow
        req_gap = 1;
        send_samples(100, 16'h0A00, 1);
        acq_en = 1'b0;
        repeat (2) @(negedge clk);
        check("acq low clears ovf", 32'(buf_overflow), 32'd0);
        acq_en = 1'b1;
        bg = got.size();
        bb = blocks_done;
        send_samples(WORDS, 16'h1000, 1);
        wait_blocks(bb + 1, "acqdrop");
        check_block(bg, 16'h1000, "acqdrop data");
        check("acqdrop blk_cnt", 32'(blk_cnt), 32'd3);

        // reset asserted mid-transfer after 40 requests
        br = req_count;
        send_samples(WORDS, 16'h2000, 1);
        cyc = 0;
        while (req_count - br < 40 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("midxfer reached 40 req", 32'(req_count - br >= 40), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst wr_start_en",  32'(wr_start_en),  32'd0);
        check("midrst wr_data",      32'(wr_data),      32'h0);
        check("midrst buf_overflow", 32'(buf_overflow), 32'd0);
        check("midrst blk_cnt",      32'(blk_cnt),      32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bg = got.size();
        bb = blocks_done;
        send_samples(WORDS, 16'h3000, 1);
        wait_blocks(bb + 1, "postrst");
        check_block(bg, 16'h3000, "postrst data");
        check("postrst blk_cnt", 32'(blk_cnt), 32'd1);

        // spurious request while idle leaves the returned word alone
        spur_req = 1'b1;
        @(negedge clk);
        spur_req = 1'b0;
        @(negedge clk);
        check("spurious wr_data", 32'(wr_data), 32'h30FF);
        check("spurious no start", 32'(wr_start_en), 32'd0);
        bg = got.size();
        bb = blocks_done;
        send_samples(WORDS, 16'h4000, 1);
        wait_blocks(bb + 1, "afterspur");
        check_block(bg, 16'h4000, "afterspur data");
        check("afterspur blk_cnt", 32'(blk_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
